// File: rtl/vcve2_pkg.sv
// Shared types for the multdiv sharing logic: the multdiv operator encoding and the
// arbiter's state enum.
package vcve2_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MdArbIdle  = 2'b00,
    MdArbBusy  = 2'b01,
    MdArbDrain = 2'b10
  } md_arb_state_e;

  function automatic logic md_op_is_mult(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/cve2_rr_arb2.sv
// Two-input picker: fixed priority to input 0, or round-robin using the last granted input.
module cve2_rr_arb2 #(
  parameter bit ScalarPriority = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // Reset value 1 makes port 0 the winner of the first contention.
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = (ScalarPriority || last_q) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/cve2_multdiv_arbiter.sv
// Shares the execute block's multiplier/divider between the scalar ID stage (port 0) and
// the vector unit (port 1); absorbs scalar flushes by draining the unit without a response.
module cve2_multdiv_arbiter
  import vcve2_pkg::*;
#(
  parameter bit ScalarPriority = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  md_op_e      req_operator_i    [2],
  input  logic [1:0]  req_signed_mode_i [2],
  input  logic [31:0] req_op_a_i        [2],
  input  logic [31:0] req_op_b_i        [2],
  input  logic        scalar_kill_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output md_op_e      multdiv_operator_o,
  output logic [1:0]  multdiv_signed_mode_o,
  output logic [31:0] multdiv_operand_a_o,
  output logic [31:0] multdiv_operand_b_o,
  input  logic        ex_valid_i,
  input  logic [31:0] result_ex_i,
  output logic [1:0]  rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        busy_o
);

  md_arb_state_e state_q, state_d;
  logic          owner_q, owner_d;
  md_op_e        op_q, op_d;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [1:0]    arb_req, gnt;
  logic          sel, kill_owned, drive, is_mult;

  assign arb_req = (state_q == MdArbIdle && !rst_i) ?
                   (req_valid_i & {1'b1, ~scalar_kill_i}) : 2'b00;

  cve2_rr_arb2 #(
    .ScalarPriority(ScalarPriority)
  ) u_arb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(arb_req),
    .gnt_o(gnt)
  );

  assign req_ready_o = gnt;
  assign sel         = gnt[1];
  assign kill_owned  = scalar_kill_i && !owner_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_o = 2'b00;
    unique case (state_q)
      MdArbIdle: begin
        if (|gnt) begin
          state_d = MdArbBusy;
          owner_d = sel;
          op_d    = req_operator_i[sel];
          mode_d  = req_signed_mode_i[sel];
          a_d     = req_op_a_i[sel];
          b_d     = req_op_b_i[sel];
        end
      end
      MdArbBusy: begin
        if (ex_valid_i) begin
          state_d = MdArbIdle;
          if (!kill_owned) rsp_valid_o[owner_q] = 1'b1;
        end else if (kill_owned) begin
          state_d = MdArbDrain;
        end
      end
      MdArbDrain: begin
        if (ex_valid_i) state_d = MdArbIdle;
      end
      default: state_d = MdArbIdle;
    endcase
  end

  assign rsp_data_o = (|rsp_valid_o) ? result_ex_i : 32'd0;

  // Drain keeps driving the unit so its internal sequence completes undisturbed.
  assign drive                 = (state_q != MdArbIdle);
  assign is_mult               = md_op_is_mult(op_q);
  assign busy_o                = drive;
  assign mult_en_o             = drive & is_mult;
  assign mult_sel_o            = drive & is_mult;
  assign div_en_o              = drive & ~is_mult;
  assign div_sel_o             = drive & ~is_mult;
  assign multdiv_operator_o    = drive ? op_q : MD_OP_MULL;
  assign multdiv_signed_mode_o = drive ? mode_q : 2'b00;
  assign multdiv_operand_a_o   = drive ? a_q : 32'd0;
  assign multdiv_operand_b_o   = drive ? b_q : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MdArbIdle;
      owner_q <= 1'b0;
      op_q    <= MD_OP_MULL;
      mode_q  <= 2'b00;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_cve2_multdiv_arbiter.sv
// Bench for the multdiv arbiter: a round-robin and a scalar-priority instance share stimulus
// and are both checked every cycle against a transaction-level model.
module tb_cve2_multdiv_arbiter;
  import vcve2_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  md_op_e      op_in   [2];
  logic [1:0]  mode_in [2];
  logic [31:0] a_in    [2];
  logic [31:0] b_in    [2];
  logic        kill, ex_valid;
  logic [31:0] res;

  logic [1:0]  ready_w [2];
  logic        mult_en_w [2], div_en_w [2], mult_sel_w [2], div_sel_w [2], busy_w [2];
  md_op_e      oper_w [2];
  logic [1:0]  smode_w [2], rspv_w [2];
  logic [31:0] opa_w [2], opb_w [2], rspd_w [2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cve2_multdiv_arbiter #(.ScalarPriority(1'b0)) dut_rr (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready_w[0]),
    .req_operator_i(op_in), .req_signed_mode_i(mode_in), .req_op_a_i(a_in),
    .req_op_b_i(b_in), .scalar_kill_i(kill), .mult_en_o(mult_en_w[0]),
    .div_en_o(div_en_w[0]), .mult_sel_o(mult_sel_w[0]), .div_sel_o(div_sel_w[0]),
    .multdiv_operator_o(oper_w[0]), .multdiv_signed_mode_o(smode_w[0]),
    .multdiv_operand_a_o(opa_w[0]), .multdiv_operand_b_o(opb_w[0]),
    .ex_valid_i(ex_valid), .result_ex_i(res), .rsp_valid_o(rspv_w[0]),
    .rsp_data_o(rspd_w[0]), .busy_o(busy_w[0])
  );

  cve2_multdiv_arbiter #(.ScalarPriority(1'b1)) dut_sp (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready_w[1]),
    .req_operator_i(op_in), .req_signed_mode_i(mode_in), .req_op_a_i(a_in),
    .req_op_b_i(b_in), .scalar_kill_i(kill), .mult_en_o(mult_en_w[1]),
    .div_en_o(div_en_w[1]), .mult_sel_o(mult_sel_w[1]), .div_sel_o(div_sel_w[1]),
    .multdiv_operator_o(oper_w[1]), .multdiv_signed_mode_o(smode_w[1]),
    .multdiv_operand_a_o(opa_w[1]), .multdiv_operand_b_o(opb_w[1]),
    .ex_valid_i(ex_valid), .result_ex_i(res), .rsp_valid_o(rspv_w[1]),
    .rsp_data_o(rspd_w[1]), .busy_o(busy_w[1])
  );

  // Model, per instance k (k=1 is the scalar-priority one): an operation in flight or not,
  // whether it was flushed, and the captured request.
  bit          m_act [2] = '{1'b0, 1'b0};
  bit          m_dead[2] = '{1'b0, 1'b0};
  bit          m_own [2] = '{1'b0, 1'b0};
  bit          m_last[2] = '{1'b1, 1'b1};
  md_op_e      m_op  [2];
  logic [1:0]  m_mode[2];
  logic [31:0] m_a   [2], m_b[2];

  function automatic logic [1:0] exp_grant(int k);
    logic [1:0] elig;
    int         winner;
    if (rst || m_act[k]) return 2'b00;
    elig = valid & {1'b1, ~kill};
    if (elig != 2'b11) return elig;
    winner = (k == 1) ? 0 : (m_last[k] ? 0 : 1);
    return (winner == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] exp_rsp(int k);
    if (m_act[k] && !m_dead[k] && ex_valid && !(m_own[k] == 1'b0 && kill))
      return m_own[k] ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] g;
      g = exp_grant(k);
      if (rst) begin
        m_act[k] = 1'b0; m_dead[k] = 1'b0; m_last[k] = 1'b1;
      end else if (!m_act[k]) begin
        if (g != 2'b00) begin
          m_act[k]  = 1'b1;
          m_dead[k] = 1'b0;
          m_own[k]  = g[1];
          m_last[k] = g[1];
          m_op[k]   = op_in[g[1]];
          m_mode[k] = mode_in[g[1]];
          m_a[k]    = a_in[g[1]];
          m_b[k]    = b_in[g[1]];
        end
      end else if (ex_valid) begin
        m_act[k] = 1'b0; m_dead[k] = 1'b0;
      end else if (m_own[k] == 1'b0 && kill) begin
        m_dead[k] = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit is_mul;
        is_mul = m_act[k] && (m_op[k] == MD_OP_MULL || m_op[k] == MD_OP_MULH);
        chk("ready", k, 32'(ready_w[k]), 32'(exp_grant(k)));
        chk("busy", k, 32'(busy_w[k]), 32'(m_act[k]));
        chk("mult_en", k, 32'(mult_en_w[k]), 32'(is_mul));
        chk("mult_sel", k, 32'(mult_sel_w[k]), 32'(is_mul));
        chk("div_en", k, 32'(div_en_w[k]), 32'(m_act[k] && !is_mul));
        chk("div_sel", k, 32'(div_sel_w[k]), 32'(m_act[k] && !is_mul));
        chk("operator", k, 32'(oper_w[k]), m_act[k] ? 32'(m_op[k]) : 32'd0);
        chk("signed_mode", k, 32'(smode_w[k]), m_act[k] ? 32'(m_mode[k]) : 32'd0);
        chk("operand_a", k, opa_w[k], m_act[k] ? m_a[k] : 32'd0);
        chk("operand_b", k, opb_w[k], m_act[k] ? m_b[k] : 32'd0);
        chk("rsp_valid", k, 32'(rspv_w[k]), 32'(exp_rsp(k)));
        if (exp_rsp(k) != 2'b00) chk("rsp_data", k, rspd_w[k], res);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
  endtask

  // Both ports request; e0/e1 are the hand-derived grants for the RR and priority instances.
  task automatic contend(input logic [1:0] e0, input logic [1:0] e1);
    step();
    valid = 2'b11;
    op_in[0] = MD_OP_MULL; a_in[0] = 32'd1; b_in[0] = 32'd2;
    op_in[1] = MD_OP_MULH; a_in[1] = 32'd3; b_in[1] = 32'd4;
    at_neg();
    chk("contend_ready", 0, 32'(ready_w[0]), 32'(e0));
    chk("contend_ready", 1, 32'(ready_w[1]), 32'(e1));
    step();
    valid = 2'b00; ex_valid = 1'b1; res = 32'h1234;
    at_neg();
    chk("contend_rsp", 0, 32'(rspv_w[0]), 32'(e0));
    chk("contend_rsp", 1, 32'(rspv_w[1]), 32'(e1));
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 2'b00; kill = 1'b0; ex_valid = 1'b0; res = 32'd0;
    for (int p = 0; p < 2; p++) begin
      op_in[p] = MD_OP_MULL; mode_in[p] = 2'b00; a_in[p] = 32'd0; b_in[p] = 32'd0;
    end
    step(); chk_en = 1'b1;
    step(); rst = 1'b0;
    at_neg();
    chk("reset_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("reset_mult_en", 0, 32'(mult_en_w[0]), 32'd0);
    chk("reset_ready", 1, 32'(ready_w[1]), 32'd0);

    // Scalar MULL 7 x 6
    step();
    valid = 2'b01; op_in[0] = MD_OP_MULL; a_in[0] = 32'd7; b_in[0] = 32'd6;
    at_neg(); chk("mull_ready", 0, 32'(ready_w[0]), 32'd1);
    step(); valid = 2'b00;
    at_neg(); chk("mull_en", 0, 32'(mult_en_w[0]), 32'd1);
    chk("mull_opa", 0, opa_w[0], 32'd7);
    step(); ex_valid = 1'b1; res = 32'd42;
    at_neg(); chk("mull_rsp", 0, 32'(rspv_w[0]), 32'd1);
    chk("mull_data", 0, rspd_w[0], 32'd42);
    step(); ex_valid = 1'b0;
    at_neg(); chk("mull_idle", 0, 32'(busy_w[0]), 32'd0);

    // Contention from reset
    pulse_reset();
    contend(2'b01, 2'b01);
    contend(2'b10, 2'b01);
    contend(2'b01, 2'b01);

    // Vector signed DIV -100 / 7 with port-0 inputs toggling
    step();
    valid = 2'b10; op_in[1] = MD_OP_DIV; mode_in[1] = 2'b11;
    a_in[1] = 32'hFFFF_FF9C; b_in[1] = 32'd7;
    at_neg(); chk("div_ready", 0, 32'(ready_w[0]), 32'd2);
    step(); valid = 2'b00; op_in[1] = MD_OP_MULL; a_in[1] = 32'd0; b_in[1] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      a_in[0] = 32'(i * 3 + 1); b_in[0] = ~32'(i); op_in[0] = md_op_e'(i[1:0]);
      at_neg();
      chk("div_hold_a", 0, opa_w[0], 32'hFFFF_FF9C);
      chk("div_hold_b", 1, opb_w[1], 32'd7);
      chk("div_hold_mode", 0, 32'(smode_w[0]), 32'd3);
      step();
    end
    ex_valid = 1'b1; res = 32'hFFFF_FFF2;
    at_neg(); chk("div_rsp", 0, 32'(rspv_w[0]), 32'd2);
    chk("div_data", 1, rspd_w[1], 32'hFFFF_FFF2);
    step(); ex_valid = 1'b0;

    // Scalar DIV flushed three cycles into BUSY, vector request waiting
    valid = 2'b01; op_in[0] = MD_OP_DIV; mode_in[0] = 2'b00;
    a_in[0] = 32'd100; b_in[0] = 32'd3;
    op_in[1] = MD_OP_MULH; a_in[1] = 32'd11; b_in[1] = 32'd13;
    at_neg(); chk("kill_ready", 0, 32'(ready_w[0]), 32'd1);
    step(); valid = 2'b00;
    step();
    step(); kill = 1'b1; valid = 2'b10;
    at_neg(); chk("kill_noready", 0, 32'(ready_w[0]), 32'd0);
    step(); kill = 1'b0;
    at_neg(); chk("drain_busy", 0, 32'(busy_w[0]), 32'd1);
    chk("drain_div_en", 1, 32'(div_en_w[1]), 32'd1);
    step(); ex_valid = 1'b1; res = 32'd33;
    at_neg(); chk("drain_norsp", 0, 32'(rspv_w[0]), 32'd0);
    step(); ex_valid = 1'b0;
    at_neg(); chk("after_drain_ready", 0, 32'(ready_w[0]), 32'd2);
    step(); valid = 2'b00; ex_valid = 1'b1; res = 32'd143;
    at_neg(); chk("after_drain_rsp", 0, 32'(rspv_w[0]), 32'd2);
    step(); ex_valid = 1'b0;

    // Kill coincident with ex_valid on a scalar op
    valid = 2'b01; op_in[0] = MD_OP_MULL; a_in[0] = 32'd2; b_in[0] = 32'd3;
    step(); valid = 2'b00; kill = 1'b1; ex_valid = 1'b1; res = 32'd6;
    at_neg(); chk("kill_ex_norsp", 0, 32'(rspv_w[0]), 32'd0);
    step(); kill = 1'b0; ex_valid = 1'b0;
    at_neg(); chk("kill_ex_idle", 0, 32'(busy_w[0]), 32'd0);

    // Kill during a vector op is ignored
    step(); valid = 2'b10;
    step(); valid = 2'b00; kill = 1'b1;
    step(); ex_valid = 1'b1; res = 32'd77;
    at_neg(); chk("vkill_rsp", 0, 32'(rspv_w[0]), 32'd2);
    chk("vkill_data", 0, rspd_w[0], 32'd77);
    step(); kill = 1'b0; ex_valid = 1'b0;

    // Reset while BUSY, then a clean op
    valid = 2'b01; op_in[0] = MD_OP_MULL; a_in[0] = 32'd5; b_in[0] = 32'd9;
    step(); valid = 2'b00;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    at_neg(); chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("rst_mult_en", 1, 32'(mult_en_w[1]), 32'd0);
    chk("rst_opa", 0, opa_w[0], 32'd0);
    step(); valid = 2'b01;
    step(); valid = 2'b00; ex_valid = 1'b1; res = 32'd45;
    at_neg(); chk("post_rst_rsp", 0, 32'(rspv_w[0]), 32'd1);
    chk("post_rst_data", 1, rspd_w[1], 32'd45);
    step(); ex_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cve2_multdiv_arbiter.md
# cve2_multdiv_arbiter

Shares the single multiplier/divider inside the execute block between two requesters: the scalar ID stage (port 0) and the vector unit (port 1). It accepts one request at a time through a valid/ready handshake and registers the operands. It then drives the execute block's multdiv enable/select/operator/operand inputs until the unit reports valid, and returns the result to the owning requester. It sits between the ID stage / vector unit and `cve2_ex_block`, and absorbs scalar flushes without corrupting the shared unit.

## Interface
- `ScalarPriority`, default 1'b0: 1 = port 0 always wins contention; 0 = round-robin between ports.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  2  request valid per port (bit 0 scalar, bit 1 vector).
- `req_ready_o`  out  2  request accepted this cycle (one-hot or zero).
- `req_operator_i`  in  2x`md_op_e`  operation per port.
- `req_signed_mode_i`  in  2x2  signed mode per port.
- `req_op_a_i`, `req_op_b_i`  in  2x32  operands per port.
- `scalar_kill_i`  in  1  scalar flush; cancels a port-0 request pending or in flight.
- `mult_en_o`, `div_en_o`  out  1  dynamic enables to execute block.
- `mult_sel_o`, `div_sel_o`  out  1  static selects to execute block.
- `multdiv_operator_o`  out  `md_op_e`;  `multdiv_signed_mode_o`  out  2;  `multdiv_operand_a_o`, `multdiv_operand_b_o`  out  32.
- `ex_valid_i`  in  1  execute block valid (multdiv selected).
- `result_ex_i`  in  32  execute block result.
- `rsp_valid_o`  out  2  one-cycle result strobe to owning port.
- `rsp_data_o`  out  32  result, valid when any `rsp_valid_o` bit is set.
- `busy_o`  out  1  state != IDLE.

## Operation
- States: IDLE, BUSY, DRAIN.
- IDLE: arbitration picks at most one valid port.
  - Port 0 is not eligible while `scalar_kill_i` is high.
  - Winner gets `req_ready_o`; operator, signed mode, operands and owner are registered; next state BUSY.
  - No valid request: stay IDLE, all outputs to execute block zero.
- Round-robin: `last_q` holds the last granted port. On contention the other port wins; `last_q` updates on every grant. With `ScalarPriority`=1, `last_q` is ignored.
- Decode: MULL/MULH set mult; DIV/REM set div.
- BUSY: drive `*_sel_o` and `*_en_o` for the registered class, plus the registered operator, mode and operands, every cycle.
  - On `ex_valid_i`: `rsp_valid_o[owner]`=1, `rsp_data_o`=`result_ex_i` (combinational, same cycle); next state IDLE.
- `scalar_kill_i` in BUSY with owner 0: next state DRAIN; no response is issued for that op.
- DRAIN: same drive as BUSY so the unit's internal FSM finishes cleanly. `rsp_valid_o` is held 0. On `ex_valid_i`, next state IDLE.
- Kill ignored: in BUSY when owner is 1, and in DRAIN.
- Kill in the same cycle as `ex_valid_i` in BUSY, owner 0: response suppressed; next state IDLE.
- `ready_o` is only asserted in IDLE, so there is one idle cycle between consecutive ops.
- Register widths: operands 32 bits; owner 1 bit; state 2 bits.

## Timing
- Reset (`rst_i` high at clock edge): state IDLE, `last_q`=1 (port 0 wins the first contention), operand/operator registers 0. All outputs 0 from the cycle after reset.
- Reset mid-operation returns to IDLE immediately; no response is issued. The execute block sees its enables drop and must reset its own FSM.
- Latency: handshake in cycle N → enables asserted from N+1 → response in the cycle `ex_valid_i` rises. Minimum 1 cycle after accept (single-cycle multiply).
- Requester may change or deassert its inputs after the accept cycle.
- `req_ready_o` depends combinationally on `req_valid_i` and `scalar_kill_i`.
- Requesters must accept `rsp_valid_o` unconditionally; there is no response backpressure.

## Structure
- `md_op_e` from `vcve2_pkg`. Add `md_arb_state_e` {IDLE, BUSY, DRAIN} to `vcve2_pkg`.
- One sub-module: `cve2_rr_arb2`, a two-input fixed/round-robin picker holding `last_q`.

## Test plan
- Scalar MULL 7×6, no contention: ready[0] in cycle 0, enables from cycle 1, `rsp_valid_o`=01 with data 42 on `ex_valid_i`; `busy_o` back to 0 next cycle.
- Both valid in IDLE after reset, RR mode: port 0 granted first. Both re-request: port 1 granted second. A third contention grants port 0. With `ScalarPriority`=1, port 0 wins all three.
- Vector DIV -100/7 signed (mode 11): operands held constant through all BUSY cycles while port-0 inputs toggle; response 10 = -14.
- Scalar DIV, `scalar_kill_i` 3 cycles into BUSY: state goes DRAIN, enables stay asserted until `ex_valid_i`, no `rsp_valid_o`. Then a pending vector request is granted.
- Kill concurrent with `ex_valid_i` on a scalar op: no response, IDLE next. Kill during a vector op: ignored, response delivered.
- `rst_i` pulse while BUSY: all outputs 0 next cycle, no response; the following request completes correctly.
